// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding
// and the step-count derivation.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub: operands in, start/busy/done
// handshake, result with carry and signed overflow out.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             OV;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, Cout, OV
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, Cout, OV
  );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_ripple_slice.sv
// DIGIT-bit ripple-carry slice built from chained full_adder cells; also
// exposes the carry into the top bit so the caller can form signed overflow.
module ripple_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock,
// start/busy/done handshake, result registers updated only on completion.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);
  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t                 state;
  logic [WIDTH-1:0]       opa;
  logic [WIDTH-1:0]       opb;
  logic [WIDTH-1:0]       acc;
  logic                   carry;
  logic [CNT_W-1:0]       cnt;

  logic [DIGIT-1:0]       slice_s;
  logic                   slice_cout;
  logic                   slice_cmsb;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   last_step;

  ripple_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (opa[DIGIT-1:0]),
    .b        (opb[DIGIT-1:0]),
    .cin      (carry),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // New sum digits enter at the top so the LSB digit ends up at bit 0.
  assign acc_cat   = {slice_s, acc};
  assign acc_next  = WIDTH'(acc_cat >> DIGIT);
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S    <= '0;
      bus.Cout <= 1'b0;
      bus.OV   <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            opa      <= bus.A;
            opb      <= bus.sub ? ~bus.B : bus.B;
            carry    <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          acc   <= acc_next;
          carry <= slice_cout;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            bus.S    <= acc_next;
            bus.Cout <= slice_cout;
            bus.OV   <= slice_cout ^ slice_cmsb;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub with a bit-serial (DIGIT=1) and a
// nibble-serial (DIGIT=4) instance sharing clock and reset.
module tb_serial_addsub;
  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       ov;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if1 ();
  serial_addsub_if #(.WIDTH(8)) if4 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int   tests_run = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   dcnt0     = 0;
  int   dcnt1     = 0;
  res_t q0[$];
  res_t q1[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (if1.done === 1'b1) dcnt0++;
  always @(negedge clk) if (if4.done === 1'b1) dcnt1++;

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic sb);
    res_t       r;
    logic [7:0] bb;
    logic [8:0] t;
    bb   = sb ? ~b : b;
    t    = {1'b0, a} + {1'b0, bb} + {8'd0, sb};
    r.s  = t[7:0];
    r.c  = t[8];
    r.ov = (a[7] == bb[7]) && (t[7] != a[7]);
    return r;
  endfunction

  function automatic int steps_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? if1.done : if4.done;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? if1.busy : if4.busy;
  endfunction

  function automatic res_t get_res(input int d);
    res_t r;
    if (d == 0) begin r.s = if1.S; r.c = if1.Cout; r.ov = if1.OV; end
    else        begin r.s = if4.S; r.c = if4.Cout; r.ov = if4.OV; end
    return r;
  endfunction

  task automatic drive(input int d, input logic st, input logic sb,
                       input logic [7:0] a, input logic [7:0] b);
    if (d == 0) begin if1.start = st; if1.sub = sb; if1.A = a; if1.B = b; end
    else        begin if4.start = st; if4.sub = sb; if4.A = a; if4.B = b; end
  endtask

  task automatic push(input int d, input res_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic pop(input int d, output res_t r);
    r = '0;
    if (d == 0) begin if (q0.size() > 0) r = q0.pop_front(); end
    else        begin if (q1.size() > 0) r = q1.pop_front(); end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input string name, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick;
      n++;
      if (get_done(d) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++;
      fails++;
      $display("FAIL %s done_timeout got no done within %0d cycles required done=1", name, n);
    end
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic sb, input string name);
    int   n;
    bit   seen;
    res_t exp;
    res_t got;
    drive(d, 1'b1, sb, a, b);
    tick;
    drive(d, 1'b0, 1'b0, a, b);
    push(d, model(a, b, sb));
    tests_run++;
    if (get_busy(d) !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_accept got %b required 1", name, get_busy(d));
    end
    wait_done(d, name, n, seen);
    if (seen) begin
      pop(d, exp);
      got = get_res(d);
      tests_run++;
      if (n !== steps_of(d)) begin
        fails++;
        $display("FAIL %s latency got %0d required %0d", name, n, steps_of(d));
      end
      tests_run++;
      if (got.s !== exp.s) begin
        fails++;
        $display("FAIL %s S got %h required %h", name, got.s, exp.s);
      end
      tests_run++;
      if (got.c !== exp.c) begin
        fails++;
        $display("FAIL %s Cout got %b required %b", name, got.c, exp.c);
      end
      tests_run++;
      if (got.ov !== exp.ov) begin
        fails++;
        $display("FAIL %s OV got %b required %b", name, got.ov, exp.ov);
      end
      tick;
      tests_run++;
      if (get_done(d) !== 1'b0 || get_busy(d) !== 1'b0) begin
        fails++;
        $display("FAIL %s after_done got done=%b busy=%b required 0 0", name, get_done(d), get_busy(d));
      end
    end
  endtask

  task automatic test_reset;
    res_t got;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    tick;
    for (int d = 0; d < 2; d++) begin
      got = get_res(d);
      tests_run++;
      if (get_busy(d) !== 1'b0 || get_done(d) !== 1'b0) begin
        fails++;
        $display("FAIL reset_ctrl[%0d] got busy=%b done=%b required 0 0", d, get_busy(d), get_done(d));
      end
      tests_run++;
      if (got !== 10'h000) begin
        fails++;
        $display("FAIL reset_outputs[%0d] got S=%h C=%b OV=%b required 00 0 0", d, got.s, got.c, got.ov);
      end
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add;
    run_op(0, 8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    run_op(0, 8'h7F, 8'h81, 1'b0, "add_7f_81");
  endtask

  task automatic test_sub;
    run_op(0, 8'h10, 8'h20, 1'b1, "sub_10_20");
    run_op(0, 8'h80, 8'h01, 1'b1, "sub_80_01");
    run_op(0, 8'h33, 8'h33, 1'b1, "sub_33_33");
  endtask

  task automatic test_digit4;
    res_t got;
    run_op(1, 8'hFF, 8'h01, 1'b0, "d4_ff_01");
    for (int i = 0; i < 3; i++) begin
      tick;
      got = get_res(1);
      tests_run++;
      if (got.s !== 8'h00 || got.c !== 1'b1) begin
        fails++;
        $display("FAIL d4_hold[%0d] got S=%h C=%b required 00 1", i, got.s, got.c);
      end
    end
    run_op(1, 8'h80, 8'h01, 1'b1, "d4_sub_80_01");
  endtask

  task automatic test_busy_ignore;
    int   dc;
    int   n;
    bit   seen;
    res_t exp;
    res_t got;
    dc = dcnt0;
    drive(0, 1'b1, 1'b0, 8'h01, 8'h01);
    tick;
    drive(0, 1'b0, 1'b0, 8'h01, 8'h01);
    push(0, model(8'h01, 8'h01, 1'b0));
    tick;
    drive(0, 1'b1, 1'b1, 8'h7F, 8'h7F);
    tick;
    drive(0, 1'b0, 1'b0, 8'h55, 8'hAA);
    tick;
    drive(0, 1'b0, 1'b0, 8'h7F, 8'h7F);
    wait_done(0, "busy_ignore", n, seen);
    if (seen) begin
      pop(0, exp);
      got = get_res(0);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL busy_ignore_result got S=%h C=%b OV=%b required %h %b %b",
                 got.s, got.c, got.ov, exp.s, exp.c, exp.ov);
      end
    end
    repeat (15) tick;
    tests_run++;
    if (dcnt0 - dc !== 1) begin
      fails++;
      $display("FAIL busy_ignore_done_count got %0d required 1", dcnt0 - dc);
    end
  endtask

  task automatic test_reset_mid;
    int   dc;
    res_t got;
    res_t drop;
    drive(0, 1'b1, 1'b0, 8'h5A, 8'h3C);
    tick;
    drive(0, 1'b0, 1'b0, 8'h5A, 8'h3C);
    push(0, model(8'h5A, 8'h3C, 1'b0));
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pop(0, drop);
    dc  = dcnt0;
    got = get_res(0);
    tests_run++;
    if (get_busy(0) !== 1'b0 || get_done(0) !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_ctrl got busy=%b done=%b required 0 0", get_busy(0), get_done(0));
    end
    tests_run++;
    if (got !== 10'h000) begin
      fails++;
      $display("FAIL reset_mid_outputs got S=%h C=%b OV=%b required 00 0 0", got.s, got.c, got.ov);
    end
    repeat (12) tick;
    tests_run++;
    if (dcnt0 !== dc) begin
      fails++;
      $display("FAIL reset_mid_no_done got %0d done pulses required 0", dcnt0 - dc);
    end
    run_op(0, 8'h03, 8'h04, 1'b0, "after_reset_03_04");
  endtask

  task automatic test_back_to_back(input int d);
    int   n;
    bit   seen;
    int   t1;
    int   t2;
    res_t exp;
    res_t got;
    t1 = 0;
    t2 = -100;
    drive(d, 1'b1, 1'b0, 8'h21, 8'h12);
    tick;
    drive(d, 1'b0, 1'b0, 8'h21, 8'h12);
    push(d, model(8'h21, 8'h12, 1'b0));
    wait_done(d, "b2b_first", n, seen);
    t1 = cyc;
    if (seen) begin
      pop(d, exp);
      got = get_res(d);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_first[%0d] got S=%h required %h", d, got.s, exp.s);
      end
    end
    tick;
    drive(d, 1'b1, 1'b1, 8'h05, 8'h09);
    tick;
    drive(d, 1'b0, 1'b0, 8'h05, 8'h09);
    push(d, model(8'h05, 8'h09, 1'b1));
    wait_done(d, "b2b_second", n, seen);
    if (seen) begin
      t2 = cyc;
      pop(d, exp);
      got = get_res(d);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_second[%0d] got S=%h C=%b OV=%b required %h %b %b",
                 d, got.s, got.c, got.ov, exp.s, exp.c, exp.ov);
      end
      tests_run++;
      if (t2 - t1 !== steps_of(d) + 2) begin
        fails++;
        $display("FAIL b2b_spacing[%0d] got %0d required %0d", d, t2 - t1, steps_of(d) + 2);
      end
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_digit4;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back(0);
    test_back_to_back(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
